// File: rtl/pool_window_feeder.sv
// pool_window_feeder: reorders a row-major activation stream into
// 2x2 window order (TL, TR, BL, BR) for the max-pooling stage.
module pool_window_feeder #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 32,
    parameter int CW     = $clog2(MAX_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CW-1:0]     cfg_width,
    input  logic [7:0]        cfg_height,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_en,
    output logic              out_last,
    output logic              busy
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_BOT0,
        S_BOT1,
        S_EMIT1,
        S_EMIT2,
        S_EMIT3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [6:0]        rowp_q, rowp_d;
    logic [CW-1:0]     w_q, w_d;
    logic [7:0]        h_q, h_d;
    logic [DATA_W-1:0] hold0_q, hold0_d;
    logic [DATA_W-1:0] hold1_q, hold1_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_en_q, out_en_d;
    logic              out_last_q, out_last_d;

    logic [DATA_W-1:0] linebuf [MAX_W];
    logic              lb_we;

    logic [CW-1:0]     wf;
    logic [7:0]        hf;
    logic              cfg_ok;
    logic              xfer;
    logic              col_last;
    logic              rowp_last;

    // Bit 0 of both dimensions is masked so frames are always even.
    assign wf       = cfg_width & ~CW'(1);
    assign hf       = cfg_height & 8'hFE;
    assign cfg_ok   = (wf != '0) && (wf <= CW'(MAX_W)) && (hf != 8'd0);

    assign in_ready = (state_q == S_TOP)  ||
                      (state_q == S_BOT0) ||
                      (state_q == S_BOT1);
    assign busy     = (state_q != S_IDLE);
    assign xfer     = in_valid & in_ready;

    assign col_last  = (col_q == w_q - CW'(1));
    assign rowp_last = ({rowp_q, 1'b0} == h_q - 8'd2);

    assign out      = out_q;
    assign out_en   = out_en_q;
    assign out_last = out_last_q;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        rowp_d     = rowp_q;
        w_d        = w_q;
        h_d        = h_q;
        hold0_d    = hold0_q;
        hold1_d    = hold1_q;
        out_d      = out_q;
        out_en_d   = 1'b0;
        out_last_d = 1'b0;
        lb_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && cfg_ok) begin
                    w_d     = wf;
                    h_d     = hf;
                    col_d   = '0;
                    rowp_d  = '0;
                    state_d = S_TOP;
                end
            end
            S_TOP: begin
                if (xfer) begin
                    lb_we = 1'b1;
                    if (col_last) begin
                        col_d   = '0;
                        state_d = S_BOT0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_BOT0: begin
                if (xfer) begin
                    hold0_d = in;
                    col_d   = col_q + CW'(1);
                    state_d = S_BOT1;
                end
            end
            S_BOT1: begin
                // col already points at the odd (right) column here.
                if (xfer) begin
                    hold1_d  = in;
                    out_d    = linebuf[col_q[AW-1:0] - AW'(1)];
                    out_en_d = 1'b1;
                    state_d  = S_EMIT1;
                end
            end
            S_EMIT1: begin
                out_d    = linebuf[col_q[AW-1:0]];
                out_en_d = 1'b1;
                state_d  = S_EMIT2;
            end
            S_EMIT2: begin
                out_d    = hold0_q;
                out_en_d = 1'b1;
                state_d  = S_EMIT3;
            end
            S_EMIT3: begin
                out_d    = hold1_q;
                out_en_d = 1'b1;
                if (!col_last) begin
                    col_d   = col_q + CW'(1);
                    state_d = S_BOT0;
                end else if (!rowp_last) begin
                    col_d   = '0;
                    rowp_d  = rowp_q + 7'd1;
                    state_d = S_TOP;
                end else begin
                    out_last_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            rowp_q     <= '0;
            w_q        <= '0;
            h_q        <= '0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            out_q      <= '0;
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            rowp_q     <= rowp_d;
            w_q        <= w_d;
            h_q        <= h_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
            out_q      <= out_d;
            out_en_q   <= out_en_d;
            out_last_q <= out_last_d;
        end
    end

    // Line buffer holds the even row; deliberately left without reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[col_q[AW-1:0]] <= in;
        end
    end

endmodule
